spart_baud_cfg_ctrl: RTL and testbench
======================================

Name: spart_baud_cfg_ctrl

Overview:
Bus-side controller that owns the ioaddr/databus write path into the SPART baud generator and shares it with a single user requester.
- After reset, and whenever the 2-bit baud select changes, it programs the 16-bit divisor: low byte at ioaddr 2'b10, then high byte at ioaddr 2'b11.
- Otherwise it grants one-cycle user bus writes through a req/ack handshake.
- It guarantees ioaddr never presents 2'b10/2'b11 except during a divisor write.

Parameters:
- DIV0, 16'd650 (0x028A), divisor for br_cfg=2'b00 (4800 baud @ 50 MHz, 16x oversample)
- DIV1, 16'd324 (0x0144), divisor for br_cfg=2'b01 (9600)
- DIV2, 16'd162 (0x00A2), divisor for br_cfg=2'b10 (19200)
- DIV3, 16'd80 (0x0050), divisor for br_cfg=2'b11 (38400)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset: synchronous, active-high
- br_cfg  input  2  baud select (board switches, pre-synchronised)
- user_req  input  1  user write request; held high until user_ack
- user_ioaddr  input  2  user target address
- user_data  input  8  user write data
- user_ack  output  1  one-cycle pulse: user request completed
- user_err  output  1  one-cycle pulse with user_ack: request rejected
- ioaddr  output  2  address to SPART / baud generator
- databus_out  output  8  write data onto databus
- bus_drive  output  1  databus drive enable (upstream tristate)
- cfg_busy  output  1  divisor programming pending or in progress
- cfg_done  output  1  divisor programmed for current cfg_sel

Behaviour:
- Single FSM: LATCH, CFG_LO, CFG_HI, READY, USER, ERR.
- State register, cfg_sel[1:0] and user capture registers are flops. Outputs are a Moore decode of these registers, so they are glitch-free and change only at posedge.
- rst (sampled at posedge) forces state=LATCH, cfg_sel=2'b00 and cfg_done=0. Resulting output values: ioaddr=2'b01, databus_out=8'h00, bus_drive=0, user_ack=0, user_err=0, cfg_busy=1, cfg_done=0.
- Reset asserted mid-sequence aborts immediately, including a half-written divisor. The full sequence is redone after release.
- LATCH: cfg_sel<=br_cfg; next CFG_LO. Outputs as reset.
- CFG_LO: ioaddr=2'b10, databus_out=DIVn[7:0] (n=cfg_sel), bus_drive=1, cfg_busy=1; next CFG_HI.
- CFG_HI: ioaddr=2'b11, databus_out=DIVn[15:8], bus_drive=1, cfg_busy=1; cfg_done<=1 at exit; next READY.
- READY: ioaddr=2'b01, bus_drive=0, databus_out=0, cfg_busy=0. Priority order:
  - (1) br_cfg!=cfg_sel -> LATCH, with cfg_done<=0.
  - (2) user_req and user_ioaddr in {2'b00,2'b01} -> USER; capture user_ioaddr and user_data.
  - (3) user_req and user_ioaddr in {2'b10,2'b11} -> ERR.
  - (4) otherwise stay.
- USER (1 cycle): ioaddr=captured addr, databus_out=captured data, bus_drive=1, user_ack=1; next READY.
- ERR (1 cycle): user_ack=1, user_err=1, ioaddr=2'b01, bus_drive=0; next READY. No bus write occurs.
- Latency:
  - Reset release to first divisor byte: 2 cycles (LATCH, then CFG_LO).
  - user_req seen in READY to user_ack: 1 cycle.
  - Back-to-back user requests: one transfer every 2 cycles, since READY is always revisited.
- br_cfg changes during CFG_LO/CFG_HI/USER/ERR are not acted on until READY. The programmed value always matches cfg_sel.
- br_cfg change and user_req in the same READY cycle: reconfiguration wins. user_req stays pending, with no ack, and is served after the next CFG_HI->READY.
- user_req dropped before ack: no transfer, no error.
- The new divisor takes effect in the baud generator at its next terminal count. This block does not wait for that.

Optional Feature:
SPART_DIRECT_DIV_EN
- Defined: user requests to 2'b10/2'b11 are legal and take the USER path with no user_err. cfg_sel and cfg_done are unchanged. A table divisor is reapplied only on a later br_cfg change or reset.
- Undefined: such requests go to ERR as specified above.

Test Plan:
- br_cfg=2'b01, rst high 2 cycles then low -> cycle+1 ioaddr=10 databus_out=8'h44 bus_drive=1; cycle+2 ioaddr=11 databus_out=8'h01; cycle+3 ioaddr=01 cfg_done=1 cfg_busy=0.
- In READY, user_req=1 user_ioaddr=00 user_data=8'hA5 -> next cycle ioaddr=00 databus_out=A5 bus_drive=1 user_ack=1 user_err=0; following cycle ioaddr=01 bus_drive=0.
- In READY, user_req with user_ioaddr=11 (macro undefined) -> user_ack=1 user_err=1, ioaddr stays 01, bus_drive=0. With SPART_DIRECT_DIV_EN defined -> ioaddr=11 driven with user_data, user_err=0.
- br_cfg 01->11 in the same cycle as user_req (addr 01, data 8'h3C) -> LATCH, CFG_LO (8'h50), CFG_HI (8'h00), READY, then USER with 8'h3C and ack. No ack before cfg_done=1.
- br_cfg toggled during CFG_LO -> CFG_HI completes the old table byte, then READY detects the mismatch and re-runs the sequence with the new divisor.
- rst asserted during CFG_HI -> next cycle state LATCH with all reset output values; full sequence restarts 2 cycles after release.
- Continuous monitor: ioaddr in {10,11} only when state is CFG_LO/CFG_HI, or USER under SPART_DIRECT_DIV_EN.

Source files
------------

// File: rtl/spart_baud_cfg_ctrl.sv
// spart_baud_cfg_ctrl: owns the ioaddr/databus write path into the SPART baud
// generator. It programs the 16-bit divisor (low byte at 2'b10, high byte at
// 2'b11) after reset and on every baud-select change. In between, it grants
// one-cycle user bus writes through a req/ack handshake.
// Optional macro SPART_DIRECT_DIV_EN: when defined, user writes to 2'b10/2'b11
// are accepted as normal transfers instead of being rejected.
// Every output is a Moore decode of registered state only.
module spart_baud_cfg_ctrl #(
  parameter logic [15:0] DIV0 = 16'd650,
  parameter logic [15:0] DIV1 = 16'd324,
  parameter logic [15:0] DIV2 = 16'd162,
  parameter logic [15:0] DIV3 = 16'd80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       user_req,
  input  logic [1:0] user_ioaddr,
  input  logic [7:0] user_data,
  output logic       user_ack,
  output logic       user_err,
  output logic [1:0] ioaddr,
  output logic [7:0] databus_out,
  output logic       bus_drive,
  output logic       cfg_busy,
  output logic       cfg_done
);

  typedef enum logic [2:0] {
    S_LATCH,
    S_CFG_LO,
    S_CFG_HI,
    S_READY,
    S_USER,
    S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cfg_sel_q, cfg_sel_d;
  logic       cfg_done_q, cfg_done_d;
  logic [1:0] uaddr_q, uaddr_d;
  logic [7:0] udata_q, udata_d;
  logic [15:0] div_cur;
  logic       user_addr_ok;

  function automatic logic [15:0] div_lookup(input logic [1:0] sel);
    case (sel)
      2'b00:   div_lookup = DIV0;
      2'b01:   div_lookup = DIV1;
      2'b10:   div_lookup = DIV2;
      default: div_lookup = DIV3;
    endcase
  endfunction

  assign div_cur = div_lookup(cfg_sel_q);

  // A user address is serviceable unless it targets the divisor registers
`ifdef SPART_DIRECT_DIV_EN
  assign user_addr_ok = 1'b1;
`else
  assign user_addr_ok = ~user_ioaddr[1];
`endif

  // Control registers: state, latched baud select and done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LATCH;
      cfg_sel_q  <= 2'b00;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_sel_q  <= cfg_sel_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  // User capture registers carry data only, so they need no reset
  always_ff @(posedge clk) begin
    uaddr_q <= uaddr_d;
    udata_q <= udata_d;
  end

  // Next-state logic; reconfiguration has priority over user requests in READY
  always_comb begin
    state_d    = state_q;
    cfg_sel_d  = cfg_sel_q;
    cfg_done_d = cfg_done_q;
    uaddr_d    = uaddr_q;
    udata_d    = udata_q;
    case (state_q)
      S_LATCH: begin
        cfg_sel_d = br_cfg;
        state_d   = S_CFG_LO;
      end
      S_CFG_LO: state_d = S_CFG_HI;
      S_CFG_HI: begin
        cfg_done_d = 1'b1;
        state_d    = S_READY;
      end
      S_READY: begin
        if (br_cfg != cfg_sel_q) begin
          cfg_done_d = 1'b0;
          state_d    = S_LATCH;
        end else if (user_req && user_addr_ok) begin
          uaddr_d = user_ioaddr;
          udata_d = user_data;
          state_d = S_USER;
        end else if (user_req) begin
          state_d = S_ERR;
        end
      end
      S_USER:  state_d = S_READY;
      S_ERR:   state_d = S_READY;
      default: state_d = S_LATCH;
    endcase
  end

  // Moore output decode; ioaddr parks at 2'b01 whenever the bus is idle
  always_comb begin
    ioaddr      = 2'b01;
    databus_out = 8'h00;
    bus_drive   = 1'b0;
    user_ack    = 1'b0;
    user_err    = 1'b0;
    cfg_busy    = 1'b0;
    cfg_done    = cfg_done_q;
    case (state_q)
      S_LATCH: cfg_busy = 1'b1;
      S_CFG_LO: begin
        ioaddr      = 2'b10;
        databus_out = div_cur[7:0];
        bus_drive   = 1'b1;
        cfg_busy    = 1'b1;
      end
      S_CFG_HI: begin
        ioaddr      = 2'b11;
        databus_out = div_cur[15:8];
        bus_drive   = 1'b1;
        cfg_busy    = 1'b1;
      end
      S_USER: begin
        ioaddr      = uaddr_q;
        databus_out = udata_q;
        bus_drive   = 1'b1;
        user_ack    = 1'b1;
      end
      S_ERR: begin
        user_ack = 1'b1;
        user_err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spart_baud_cfg_ctrl.sv
// Testbench for spart_baud_cfg_ctrl: stimulus tables per scenario, expected
// output vectors queued alongside, compared one per clock.
module tb_spart_baud_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       user_req;
  logic [1:0] user_ioaddr;
  logic [7:0] user_data;
  logic       user_ack, user_err, bus_drive, cfg_busy, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] databus_out;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       rst;
    logic [1:0] br;
    logic       req;
    logic [1:0] addr;
    logic [7:0] data;
  } stim_t;

  stim_t            st_q[$];
  logic [14:0]      sb_q[$];
  logic [14:0]      obs;

  spart_baud_cfg_ctrl dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .user_req(user_req),
    .user_ioaddr(user_ioaddr), .user_data(user_data), .user_ack(user_ack),
    .user_err(user_err), .ioaddr(ioaddr), .databus_out(databus_out),
    .bus_drive(bus_drive), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  assign obs = {ioaddr, databus_out, bus_drive, user_ack, user_err, cfg_busy, cfg_done};

  // Expected output vector, packed in the same order as obs
  function automatic logic [14:0] ev(input logic [1:0] a, input logic [7:0] d,
                                     input logic drv, input logic ack, input logic err,
                                     input logic busy, input logic done);
    ev = {a, d, drv, ack, err, busy, done};
  endfunction

  function automatic stim_t sv(input logic r, input logic [1:0] b, input logic q,
                               input logic [1:0] a, input logic [7:0] d);
    sv = '{rst: r, br: b, req: q, addr: a, data: d};
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; br_cfg = s.br; user_req = s.req; user_ioaddr = s.addr; user_data = s.data;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Divisor registers may only appear on ioaddr while a divisor byte is written
  always @(negedge clk) begin
    if (rst === 1'b0 && ioaddr[1] === 1'b1) begin
      n_vec++;
`ifdef SPART_DIRECT_DIV_EN
      if (!(bus_drive && (cfg_busy || user_ack))) begin
`else
      if (!(bus_drive && cfg_busy)) begin
`endif
        n_fail++;
        $display("FAIL ioaddr_guard t=%0t: ioaddr=%b drive=%b busy=%b ack=%b", $time,
                 ioaddr, bus_drive, cfg_busy, user_ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    logic [14:0] e;
    st_q.push_back(sv(1, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(1, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b10, 8'h44, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b11, 8'h01, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_cfg cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_user_write;
    logic [14:0] e;
    st_q.push_back(sv(0, 2'b01, 1, 2'b00, 8'hA5)); sb_q.push_back(ev(2'b00, 8'hA5, 1, 1, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 1, 2'b01, 8'h5A)); sb_q.push_back(ev(2'b01, 8'h5A, 1, 1, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL user_write cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_divisor_addr;
    logic [14:0] e;
    st_q.push_back(sv(0, 2'b01, 1, 2'b11, 8'h77));
`ifdef SPART_DIRECT_DIV_EN
    sb_q.push_back(ev(2'b11, 8'h77, 1, 1, 0, 0, 1));
`else
    sb_q.push_back(ev(2'b01, 8'h00, 0, 1, 1, 0, 1));
`endif
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 1, 2'b10, 8'h99));
`ifdef SPART_DIRECT_DIV_EN
    sb_q.push_back(ev(2'b10, 8'h99, 1, 1, 0, 0, 1));
`else
    sb_q.push_back(ev(2'b01, 8'h00, 0, 1, 1, 0, 1));
`endif
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL divisor_addr cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] e;
    st_q.push_back(sv(0, 2'b01, 1, 2'b01, 8'h11)); sb_q.push_back(ev(2'b01, 8'h11, 1, 1, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 1, 2'b00, 8'h22)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 1, 2'b00, 8'h22)); sb_q.push_back(ev(2'b00, 8'h22, 1, 1, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 1, 2'b01, 8'h33)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 1, 2'b01, 8'h33)); sb_q.push_back(ev(2'b01, 8'h33, 1, 1, 0, 0, 1));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reconfig_vs_req;
    logic [14:0] e;
    st_q.push_back(sv(0, 2'b11, 1, 2'b01, 8'h3C)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b11, 1, 2'b01, 8'h3C)); sb_q.push_back(ev(2'b10, 8'h50, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b11, 1, 2'b01, 8'h3C)); sb_q.push_back(ev(2'b11, 8'h00, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b11, 1, 2'b01, 8'h3C)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b11, 1, 2'b01, 8'h3C)); sb_q.push_back(ev(2'b01, 8'h3C, 1, 1, 0, 0, 1));
    st_q.push_back(sv(0, 2'b11, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reconfig_vs_req cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_toggle_during_cfg;
    logic [14:0] e;
    st_q.push_back(sv(0, 2'b00, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b00, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b10, 8'h8A, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b10, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b11, 8'h02, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b10, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b10, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b10, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b10, 8'hA2, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b10, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b11, 8'h00, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b10, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL toggle_during_cfg cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_cfg;
    logic [14:0] e;
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b10, 8'h44, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b11, 8'h01, 1, 0, 0, 1, 0));
    st_q.push_back(sv(1, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b10, 8'h44, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b11, 8'h01, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b01, 0, 2'b00, 8'h00)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_cfg cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_req_dropped;
    logic [14:0] e;
    st_q.push_back(sv(0, 2'b00, 1, 2'b00, 8'hEE)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b00, 1, 2'b00, 8'hEE)); sb_q.push_back(ev(2'b10, 8'h8A, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b00, 1, 2'b00, 8'hEE)); sb_q.push_back(ev(2'b11, 8'h02, 1, 0, 0, 1, 0));
    st_q.push_back(sv(0, 2'b00, 0, 2'b00, 8'hEE)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    st_q.push_back(sv(0, 2'b00, 0, 2'b00, 8'hEE)); sb_q.push_back(ev(2'b01, 8'h00, 0, 0, 0, 0, 1));
    for (int i = 0; st_q.size() > 0; i++) begin
      apply(st_q.pop_front());
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL req_dropped cyc%0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; br_cfg = 2'b01; user_req = 1'b0; user_ioaddr = 2'b00; user_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_user_write();
    test_divisor_addr();
    test_back_to_back();
    test_reconfig_vs_req();
    test_toggle_during_cfg();
    test_reset_mid_cfg();
    test_req_dropped();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
